pipeline_reg_skid: RTL

//  Parametrised pipeline register stage with valid/ready handshake, 1-entry skid buffer,

---
 rtl/pipeline_reg_skid.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pipeline_reg_skid.sv
// ---------------------------------------------------------------------------
// pipeline_reg_skid
//   One pipeline register stage between two processor stages. The payload is
//   an opaque DATA_WIDTH vector that each stage packs its fields into. A
//   one-entry skid register sits beside the main register, so IN_READY is a
//   pure function of local state and never looks at OUT_READY. Back-pressure
//   therefore never ripples combinationally up the pipeline.
//
// Handshake (both sides): a payload moves on a rising edge exactly when
//   VALID and READY are both high in the cycle before that edge. VALID never
//   waits on READY. Once VALID is raised, the payload stays stable until it
//   is taken. The only exceptions are RESET and FLUSH, which drop every held
//   payload. BUSY_WAIT blocks transfers on both sides and freezes all state.
//
// Ports
//   CLK        rising-edge clock
//   RESET      asynchronous, active-high reset
//   BUSY_WAIT  global stall; no transfers, all registers hold
//   FLUSH      synchronous squash; wins over BUSY_WAIT and the handshakes
//   IN_VALID   upstream payload valid
//   IN_READY   stage can accept a payload this cycle
//   IN_DATA    upstream payload
//   OUT_VALID  OUT_DATA holds a valid payload (registered)
//   OUT_READY  downstream accepts the payload
//   OUT_DATA   registered payload to the next stage
//   OCCUPANCY  number of payloads held: 0, 1 or 2 (registered)
//   STATE_DBG  current state {main_valid, skid_valid}, for observation only
// ---------------------------------------------------------------------------
module pipeline_reg_skid #(
  parameter int                    DATA_WIDTH        = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE       = '0,
  parameter bit                    FLUSH_CLEARS_DATA = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  BUSY_WAIT,
  input  logic                  FLUSH,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic [1:0]            OCCUPANCY,
  output logic [1:0]            STATE_DBG
);

  // The encoding is {main_valid, skid_valid}. The two valid flags are read
  // straight from the state bits.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b10,
    ST_SKID  = 2'b11
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   main_q, main_d;
  logic [DATA_WIDTH-1:0]   skid_q, skid_d;
  logic [1:0]              occ_q, occ_d;

  logic main_valid;
  logic skid_valid;
  logic in_ready;
  logic in_xfer;
  logic out_xfer;

  assign main_valid = state_q[1];
  assign skid_valid = state_q[0];

  // IN_READY is held low during RESET. This avoids a transfer that looks
  // accepted upstream while the stage is being cleared.
  assign in_ready = ~skid_valid & ~BUSY_WAIT & ~FLUSH & ~RESET;
  assign in_xfer  = IN_VALID & in_ready;
  assign out_xfer = main_valid & OUT_READY & ~BUSY_WAIT;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (FLUSH) begin
      state_d = ST_EMPTY;
      if (FLUSH_CLEARS_DATA) begin
        main_d = RESET_VALUE;
        skid_d = RESET_VALUE;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d = ST_FULL;
            main_d  = IN_DATA;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            main_d = IN_DATA;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end else if (in_xfer) begin
            // Downstream stalled while a new payload arrived. Park the new
            // payload in the skid register so OUT_DATA does not change.
            state_d = ST_SKID;
            skid_d  = IN_DATA;
          end
        end
        ST_SKID: begin
          // IN_READY is low here, so the only possible event is a drain.
          if (out_xfer) begin
            state_d = ST_FULL;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    occ_d = {1'b0, state_d[1]} + {1'b0, state_d[0]};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
      occ_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      occ_q   <= occ_d;
    end
  end

  assign IN_READY  = in_ready;
  assign OUT_VALID = main_valid;
  assign OUT_DATA  = main_q;
  assign OCCUPANCY = occ_q;
  assign STATE_DBG = state_q;

endmodule
